// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory port between an instruction
// fetch requester and a data load/store requester. Data normally wins; a fetch
// that has been refused STARVE_LIMIT cycles in a row wins the next cycle. A
// one-entry owner register routes the read data returning one cycle after a
// granted read back to the requester that issued it.
//
// Handshake: a requester raises *_req with its command and holds all of it
// stable until the cycle in which *_gnt is high; that cycle is the transfer.
// Dropping *_req before *_gnt abandons the request and no response follows.
// A granted read is answered by a one-cycle *_rvalid pulse on the next cycle;
// writes are never answered. There is no back-pressure on responses.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    // Counter wide enough to hold STARVE_LIMIT (at least one bit).
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;
    logic          resp_valid;
    logic          resp_valid_next;
    owner_e        resp_owner;
    owner_e        resp_owner_next;
    logic          fetch_urgent;

    // Grant decision: data first unless fetch has starved long enough; nothing during reset.
    always_comb begin
        fetch_urgent = if_req && (starve_cnt == STARVE_MAX);
        d_gnt        = 1'b0;
        if_gnt       = 1'b0;
        if (!rst) begin
            if (d_req && !fetch_urgent) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Shared port command taken from whichever requester holds the grant.
    always_comb begin
        mem_req   = if_gnt || d_gnt;
        mem_addr  = '0;
        mem_we    = 4'h0;
        mem_wdata = 32'h0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    // Next values of the starve counter and the response-owner register.
    always_comb begin
        starve_next     = starve_cnt;
        resp_valid_next = 1'b0;
        resp_owner_next = OWNER_FETCH;
        if (!if_req || if_gnt) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_next = starve_cnt + 1'b1;
        end
        if (if_gnt) begin
            resp_valid_next = 1'b1;
            resp_owner_next = OWNER_FETCH;
        end else if (d_gnt && (d_we == 4'h0)) begin
            resp_valid_next = 1'b1;
            resp_owner_next = OWNER_DATA;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            resp_valid <= 1'b0;
            resp_owner <= OWNER_FETCH;
        end else begin
            starve_cnt <= starve_next;
            resp_valid <= resp_valid_next;
            resp_owner <= resp_owner_next;
        end
    end

    // Response steering; gating with rst kills a read granted just before reset.
    always_comb begin
        if_rvalid = !rst && resp_valid && (resp_owner == OWNER_FETCH);
        d_rvalid  = !rst && resp_valid && (resp_owner == OWNER_DATA);
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a long
// randomized run compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 3;
    localparam int AW           = 32;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic [3:0]    d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- memory environment ----------------
    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    logic [31:0] env_mem [logic [AW-1:0]];
    logic [31:0] env_w;

    // Single-cycle memory: read data one cycle after a read, junk otherwise.
    always @(posedge clk) begin
        if (mem_req && mem_we == 4'h0) begin
            mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
        end else begin
            mem_rdata <= $urandom;
        end
        if (mem_req && mem_we != 4'h0) begin
            env_w = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) env_w[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            env_mem[mem_addr] = env_w;
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: who should win this cycle, and which read answer is
    // owed next cycle (scoreboard queue of {owner, data}).
    logic [31:0] ref_mem [logic [AW-1:0]];
    int          m_fetch_wait = 0;
    logic [32:0] exp_q[$];

    logic          exp_if_gnt, exp_d_gnt, exp_mem_req;
    logic          exp_if_rvalid, exp_d_rvalid;
    logic [31:0]   exp_rdata;
    logic [AW-1:0] exp_mem_addr;
    logic [3:0]    exp_mem_we;
    logic [31:0]   exp_mem_wdata;

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- driver ----------------
    // Applies one cycle of inputs at the falling edge, advances the model,
    // then waits 1 time unit so combinational outputs can be sampled.
    task automatic drive_cycle(input logic r, input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic [3:0] dw,
                               input logic [AW-1:0] da, input logic [31:0] dd);
        logic [32:0] rsp;
        logic [31:0] w;
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        exp_if_rvalid = 1'b0;
        exp_d_rvalid  = 1'b0;
        exp_rdata     = 32'h0;
        if (exp_q.size() > 0) begin
            rsp = exp_q.pop_front();
            if (!r) begin
                exp_if_rvalid = !rsp[32];
                exp_d_rvalid  = rsp[32];
                exp_rdata     = rsp[31:0];
            end
        end
        if (r) begin
            exp_if_gnt   = 1'b0;
            exp_d_gnt    = 1'b0;
            m_fetch_wait = 0;
        end else begin
            exp_d_gnt    = dr && !(ir && m_fetch_wait >= STARVE_LIMIT);
            exp_if_gnt   = ir && !exp_d_gnt;
            m_fetch_wait = (ir && !exp_if_gnt) ? m_fetch_wait + 1 : 0;
        end
        exp_mem_req   = exp_if_gnt || exp_d_gnt;
        exp_mem_addr  = exp_d_gnt ? da : ia;
        exp_mem_we    = exp_d_gnt ? dw : 4'h0;
        exp_mem_wdata = dd;
        if (exp_if_gnt) exp_q.push_back({1'b0, ref_read(ia)});
        if (exp_d_gnt && dw == 4'h0) exp_q.push_back({1'b1, ref_read(da)});
        if (exp_d_gnt && dw != 4'h0) begin
            w = ref_read(da);
            for (int b = 0; b < 4; b++) begin
                if (dw[b]) w[8*b +: 8] = dd[8*b +: 8];
            end
            ref_mem[da] = w;
        end
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, 32'h0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 1'b1, 32'h10, 1'b1, 4'h0, 32'h20, 32'h0);
            n_checks++;
            if ({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl c%0d: got %b want 00000", c, {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid});
            end
            n_checks++;
            if (mem_we !== 4'h0) begin
                n_fail++; $display("FAIL reset_mem_we c%0d: got %h want 0", c, mem_we);
            end
        end
    endtask

    task automatic test_fetch_only();
        logic [AW-1:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) drive_cycle(1'b0, 1'b1, addrs[c], 1'b0, 4'h0, '0, 32'h0);
            else idle_cycle();
            n_checks++;
            if (if_gnt !== (c < 3) || d_gnt !== 1'b0) begin
                n_fail++; $display("FAIL fetch_gnt c%0d: got if=%b d=%b want if=%b d=0", c, if_gnt, d_gnt, c < 3);
            end
            if (c < 3) begin
                n_checks++;
                if (mem_addr !== addrs[c] || mem_we !== 4'h0) begin
                    n_fail++; $display("FAIL fetch_cmd c%0d: got addr=%h we=%h want addr=%h we=0", c, mem_addr, mem_we, addrs[c]);
                end
            end
            if (c > 0) begin
                n_checks++;
                if (if_rvalid !== 1'b1 || if_rdata !== init_word(addrs[c-1]) || d_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_rsp c%0d: got v=%b data=%h dv=%b want v=1 data=%h dv=0", c, if_rvalid, if_rdata, d_rvalid, init_word(addrs[c-1]));
                end
            end
        end
    endtask

    task automatic test_priority();
        drive_cycle(1'b0, 1'b1, 32'h100, 1'b1, 4'h0, 32'h100, 32'h0);
        n_checks++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL prio_c0: got d=%b if=%b addr=%h want d=1 if=0 addr=100", d_gnt, if_gnt, mem_addr);
        end
        drive_cycle(1'b0, 1'b1, 32'h100, 1'b0, 4'h0, '0, 32'h0);
        n_checks++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            n_fail++; $display("FAIL prio_c1_gnt: got if=%b d=%b want if=1 d=0", if_gnt, d_gnt);
        end
        n_checks++;
        if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== init_word(32'h100)) begin
            n_fail++; $display("FAIL prio_c1_rsp: got dv=%b iv=%b data=%h want dv=1 iv=0 data=%h", d_rvalid, if_rvalid, d_rdata, init_word(32'h100));
        end
        idle_cycle();
        n_checks++;
        if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== init_word(32'h100)) begin
            n_fail++; $display("FAIL prio_c2_rsp: got iv=%b dv=%b data=%h want iv=1 dv=0 data=%h", if_rvalid, d_rvalid, if_rdata, init_word(32'h100));
        end
    endtask

    task automatic test_starvation();
        logic [5:0] d_pat;
        logic [5:0] i_pat;
        logic       fetch_held;
        d_pat = 6'b110111;
        i_pat = 6'b001000;
        fetch_held = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1'b0, fetch_held, 32'h300, 1'b1, 4'h0, AW'(32'h400 + 4 * c), 32'h0);
            n_checks++;
            if (d_gnt !== d_pat[c] || if_gnt !== i_pat[c]) begin
                n_fail++; $display("FAIL starve c%0d: got d=%b if=%b want d=%b if=%b", c, d_gnt, if_gnt, d_pat[c], i_pat[c]);
            end
            n_checks++;
            if (d_rvalid !== exp_d_rvalid || if_rvalid !== exp_if_rvalid) begin
                n_fail++; $display("FAIL starve_rsp c%0d: got dv=%b iv=%b want dv=%b iv=%b", c, d_rvalid, if_rvalid, exp_d_rvalid, exp_if_rvalid);
            end
            if (if_gnt) fetch_held = 1'b0;
        end
        idle_cycle();
    endtask

    task automatic test_write_read();
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF);
        n_checks++;
        if (d_gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 4'hF || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_cmd: got gnt=%b we=%h addr=%h data=%h want gnt=1 we=f addr=200 data=deadbeef", d_gnt, mem_we, mem_addr, mem_wdata);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 4'h0, 32'h200, 32'h0);
        n_checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || mem_we !== 4'h0) begin
            n_fail++; $display("FAIL wr_no_rsp: got dv=%b gnt=%b we=%h want dv=0 gnt=1 we=0", d_rvalid, d_gnt, mem_we);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 4'b0101, 32'h200, 32'h1122_3344);
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_readback: got dv=%b data=%h want dv=1 data=deadbeef", d_rvalid, d_rdata);
        end
        n_checks++;
        if (mem_we !== 4'b0101 || mem_wdata !== 32'h1122_3344) begin
            n_fail++; $display("FAIL wr_partial_cmd: got we=%h data=%h want we=5 data=11223344", mem_we, mem_wdata);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 4'h0, 32'h200, 32'h0);
        n_checks++;
        if (d_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_partial_no_rsp: got dv=%b want 0", d_rvalid);
        end
        idle_cycle();
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDE22_BE44) begin
            n_fail++; $display("FAIL wr_partial_readback: got dv=%b data=%h want dv=1 data=de22be44", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_reset_kill();
        drive_cycle(1'b0, 1'b1, 32'h500, 1'b0, 4'h0, '0, 32'h0);
        n_checks++;
        if (if_gnt !== 1'b1) begin
            n_fail++; $display("FAIL kill_gnt: got %b want 1", if_gnt);
        end
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b1, 1'b1, 32'h504, 1'b1, 4'hF, 32'h508, 32'h1);
            n_checks++;
            if ({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid} !== 5'b0 || mem_we !== 4'h0) begin
                n_fail++; $display("FAIL kill_in_reset c%0d: got %b we=%h want 00000 we=0", c, {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid}, mem_we);
            end
        end
        drive_cycle(1'b0, 1'b1, 32'h50C, 1'b0, 4'h0, '0, 32'h0);
        n_checks++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_gnt !== 1'b1) begin
            n_fail++; $display("FAIL kill_after: got iv=%b dv=%b gnt=%b want iv=0 dv=0 gnt=1", if_rvalid, d_rvalid, if_gnt);
        end
        idle_cycle();
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== init_word(32'h50C)) begin
            n_fail++; $display("FAIL kill_first_rsp: got iv=%b data=%h want iv=1 data=%h", if_rvalid, if_rdata, init_word(32'h50C));
        end
    endtask

    task automatic test_withdraw();
        drive_cycle(1'b0, 1'b1, 32'h600, 1'b1, 4'h0, 32'h604, 32'h0);
        n_checks++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            n_fail++; $display("FAIL wd_c0: got d=%b if=%b want d=1 if=0", d_gnt, if_gnt);
        end
        idle_cycle();
        n_checks++;
        if (if_gnt !== 1'b0 || mem_req !== 1'b0 || d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL wd_c1: got gnt=%b req=%b dv=%b iv=%b want 0 0 1 0", if_gnt, mem_req, d_rvalid, if_rvalid);
        end
        idle_cycle();
        n_checks++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL wd_c2: got iv=%b dv=%b want 0 0", if_rvalid, d_rvalid);
        end
    endtask

    task automatic test_random();
        logic          ir, dr;
        logic [AW-1:0] ia, da;
        logic [3:0]    dw;
        logic [31:0]   dd;
        int            rd_grants, rsp_seen, fetch_wait;
        ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dw = 4'h0; dd = 32'h0;
        rd_grants = 0; rsp_seen = 0; fetch_wait = 0;
        for (int c = 0; c <= 10000; c++) begin
            if (c == 10000) begin
                ir = 1'b0; dr = 1'b0;
            end else begin
                if (!ir || if_gnt) begin
                    ir = 1'($urandom_range(0, 1));
                    ia = AW'($urandom_range(0, 63)) << 2;
                end else if ($urandom_range(0, 15) == 0) begin
                    ir = 1'b0;
                end
                if (!dr || d_gnt) begin
                    dr = ($urandom_range(0, 3) != 0);
                    da = AW'($urandom_range(0, 63)) << 2;
                    dw = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                    dd = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    dr = 1'b0;
                end
            end
            drive_cycle(1'b0, ir, ia, dr, dw, da, dd);
            n_checks++;
            if (if_gnt && d_gnt) begin
                n_fail++; $display("FAIL rnd_two_gnt c%0d: got if=1 d=1 want at most one", c);
            end
            n_checks++;
            if (if_gnt !== exp_if_gnt || d_gnt !== exp_d_gnt || mem_req !== exp_mem_req) begin
                n_fail++; $display("FAIL rnd_gnt c%0d: got if=%b d=%b req=%b want if=%b d=%b req=%b", c, if_gnt, d_gnt, mem_req, exp_if_gnt, exp_d_gnt, exp_mem_req);
            end
            if (exp_mem_req) begin
                n_checks++;
                if (mem_addr !== exp_mem_addr || mem_we !== exp_mem_we || (exp_d_gnt && mem_wdata !== exp_mem_wdata)) begin
                    n_fail++; $display("FAIL rnd_cmd c%0d: got addr=%h we=%h wd=%h want addr=%h we=%h wd=%h", c, mem_addr, mem_we, mem_wdata, exp_mem_addr, exp_mem_we, exp_mem_wdata);
                end
            end
            n_checks++;
            if (if_rvalid !== exp_if_rvalid || d_rvalid !== exp_d_rvalid) begin
                n_fail++; $display("FAIL rnd_rvalid c%0d: got iv=%b dv=%b want iv=%b dv=%b", c, if_rvalid, d_rvalid, exp_if_rvalid, exp_d_rvalid);
            end
            if (exp_if_rvalid || exp_d_rvalid) begin
                n_checks++;
                if ((exp_if_rvalid ? if_rdata : d_rdata) !== exp_rdata) begin
                    n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, exp_if_rvalid ? if_rdata : d_rdata, exp_rdata);
                end
            end
            if (if_gnt || (d_gnt && d_we == 4'h0)) rd_grants++;
            if (if_rvalid) rsp_seen++;
            if (d_rvalid) rsp_seen++;
            if (if_req) begin
                fetch_wait++;
                n_checks++;
                if (fetch_wait > STARVE_LIMIT + 1) begin
                    n_fail++; $display("FAIL rnd_fetch_wait c%0d: got %0d cycles want <= %0d", c, fetch_wait, STARVE_LIMIT + 1);
                end
                if (if_gnt) fetch_wait = 0;
            end else begin
                fetch_wait = 0;
            end
        end
        idle_cycle();
        if (if_rvalid) rsp_seen++;
        if (d_rvalid) rsp_seen++;
        n_checks++;
        if (rsp_seen != rd_grants) begin
            n_fail++; $display("FAIL rnd_rsp_count: got %0d responses want %0d", rsp_seen, rd_grants);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 4'h0; d_addr = '0; d_wdata = 32'h0;
        test_reset();
        idle_cycle();
        test_fetch_only();
        test_priority();
        test_starvation();
        test_write_read();
        test_reset_kill();
        test_withdraw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive denied fetch-request cycles before fetch wins priority.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  fetch read request; held with if_addr until if_gnt.
REQ-006 if_addr  input  AW  fetch word address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  32  fetch read data.
REQ-010 d_req  input  1  data request; held with d_addr, d_we and d_wdata until d_gnt.
REQ-011 d_we  input  4  byte write enables; 0 means read.
REQ-012 d_addr  input  AW  data address.
REQ-013 d_wdata  input  32  write data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  data read data valid.
REQ-016 d_rdata  output  32  data read data.
REQ-017 mem_req  output  1  single shared memory port request.
REQ-018 mem_addr, mem_we, mem_wdata  output  AW/4/32  shared port command.
REQ-019 mem_rdata  input  32  memory read data, valid exactly 1 cycle after a read with mem_req=1.

Function
REQ-020 The arbiter SHALL grant at most one requester per cycle; grants are combinational from the current requests and state.
REQ-021 mem_req SHALL equal if_gnt OR d_gnt; mem_addr, mem_we and mem_wdata SHALL come from the granted requester, with mem_we=0 on a fetch grant.
REQ-022 Default priority SHALL be data over fetch.
REQ-023 Starve counter: it SHALL increment, saturating at STARVE_LIMIT, each cycle if_req=1 and if_gnt=0, and clear on if_gnt or if_req=0.
REQ-024 When the starve counter equals STARVE_LIMIT and if_req=1, fetch SHALL be granted over a pending data request.
REQ-025 If only one request is asserted, it SHALL be granted in that cycle (zero added latency).
REQ-026 The response-owner register SHALL record {valid, owner} for each granted read and SHALL be cleared for writes or idle cycles.
REQ-027 The cycle after a granted read, exactly one rvalid SHALL pulse for that owner, with its rdata equal to mem_rdata.
REQ-028 A granted write (d_we != 0) SHALL produce no d_rvalid.
REQ-029 if_rdata and d_rdata SHALL both be driven with mem_rdata; they are meaningful only while the matching rvalid is high.
REQ-030 Back-to-back grants SHALL be allowed every cycle; a response and a new grant in the same cycle are legal and independent.
REQ-031 A request withdrawn before its grant SHALL be dropped without a response.

Reset
REQ-032 While rst=1: if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, mem_we = 0; starve counter = 0; response-owner valid = 0.
REQ-033 A read granted in the cycle before rst rises SHALL NOT produce an rvalid after reset.
REQ-034 Requests SHALL be evaluated from the first cycle after rst falls.

Verification
REQ-035 Fetch only, if_req=1 with addr 0x0,0x4,0x8 in consecutive cycles -> if_gnt=1 on each; if_rvalid the following cycle with the matching mem_rdata; d_gnt=0 throughout.
REQ-036 Simultaneous if_req and d_req read at 0x100 -> d_gnt in cycle 0 and if_gnt in cycle 1; d_rvalid in cycle 1 and if_rvalid in cycle 2, each carrying correct data.
REQ-037 STARVE_LIMIT=3 with d_req held continuously plus if_req -> d_gnt in cycles 0-2, if_gnt in cycle 3, then d_gnt resumes in cycle 4.
REQ-038 Data write d_we=4'hF, addr 0x200, wdata 0xDEADBEEF -> mem_we=4'hF with matching addr and data in the grant cycle; no d_rvalid; a subsequent read of 0x200 returns 0xDEADBEEF.
REQ-039 Read granted, then rst=1 on the next edge -> no rvalid; all outputs 0 during reset.
REQ-040 Random if_req/d_req traffic for 10k cycles -> never two grants in one cycle; rvalid count equals read-grant count; fetch wait never exceeds STARVE_LIMIT+1 cycles.
